// File: rtl/f1_launch_ctrl_if.sv
// f1_launch_ctrl_if: bundles the launch controller's stimulus inputs and
// status/result outputs.
//   tick, start, btn     timebase pulse, sequence request, driver button
//   lights_in[7:0]       light pattern from f1_fsm
//   fsm_en               one-cycle advance pulse to f1_fsm en
//   busy                 controller not idle
//   delay_val[8:0]       all-lit hold length in ticks (latched on HOLD entry)
//   result_valid         one-cycle result strobe
//   reaction_time, jump_start, timeout   result fields, held until next strobe
// Modports: slave = controller side, master = environment side.
interface f1_launch_ctrl_if #(
    parameter int CNT_W = 12
);
    logic             tick;
    logic             start;
    logic             btn;
    logic [7:0]       lights_in;
    logic             fsm_en;
    logic             busy;
    logic [8:0]       delay_val;
    logic             result_valid;
    logic [CNT_W-1:0] reaction_time;
    logic             jump_start;
    logic             timeout;

    modport slave (
        input  tick, start, btn, lights_in,
        output fsm_en, busy, delay_val, result_valid, reaction_time, jump_start, timeout
    );

    modport master (
        output tick, start, btn, lights_in,
        input  fsm_en, busy, delay_val, result_valid, reaction_time, jump_start, timeout
    );
endinterface

// File: rtl/f1_launch_ctrl.sv
// f1_launch_ctrl: F1 start-light sequencer and reaction timer wrapped around
// f1_fsm. Steps the lights up on ticks, holds all-lit for DELAY_MIN + LFSR
// ticks, commands lights-out, then counts ticks until the button press.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   f1_launch_ctrl_if.slave (tick/start/btn/lights_in in; fsm_en, busy,
//         delay_val, result_valid, reaction_time, jump_start, timeout out)
// Parameters: CNT_W (reaction counter width), DELAY_MIN (minimum hold ticks).
// Build option: define F1_BTN_SYNC_EN to pass btn through a 2-flop
// synchronizer before edge detection (+2 cycles press latency).
module f1_launch_ctrl #(
    parameter int CNT_W     = 12,
    parameter int DELAY_MIN = 16
) (
    input logic             clk,
    input logic             rst,
    f1_launch_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEQ   = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] ARMED = 2'd3;

    localparam logic [7:0]       ALL_OFF  = '0;
    localparam logic [7:0]       ALL_ON   = '1;
    localparam logic [8:0]       DLY_BASE = 9'(DELAY_MIN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_MAX - CNT_ONE;

    logic [1:0]       state;
    logic [6:0]       lfsr;
    logic [8:0]       hold_len;
    logic [8:0]       hold_cnt;
    logic [CNT_W-1:0] rcnt;
    logic             btn_in;
    logic             btn_prev;
    logic             press;

`ifdef F1_BTN_SYNC_EN
    logic btn_s1;
    logic btn_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= bus.btn;
            btn_s2 <= btn_s1;
        end
    end

    assign btn_in = btn_s2;
`else
    assign btn_in = bus.btn;
`endif

    // Press is registered, so the FSM acts one cycle after the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_prev <= 1'b0;
            press    <= 1'b0;
        end else begin
            btn_prev <= btn_in;
            press    <= btn_in & ~btn_prev;
        end
    end

    // x^7 + x^6 + 1, free-running; nonzero seed keeps it off the zero state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 7'h01;
        else      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end

    assign hold_len = DLY_BASE + {2'b00, lfsr};
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            hold_cnt          <= '0;
            rcnt              <= '0;
            bus.fsm_en        <= 1'b0;
            bus.delay_val     <= '0;
            bus.result_valid  <= 1'b0;
            bus.reaction_time <= '0;
            bus.jump_start    <= 1'b0;
            bus.timeout       <= 1'b0;
        end else begin
            bus.fsm_en       <= 1'b0;
            bus.result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && bus.lights_in == ALL_OFF) state <= SEQ;
                end
                SEQ: begin
                    if (bus.lights_in == ALL_ON) begin
                        bus.delay_val <= hold_len;
                        hold_cnt      <= hold_len;
                        state         <= HOLD;
                    end else if (bus.tick) begin
                        bus.fsm_en <= 1'b1;
                    end
                end
                HOLD: begin
                    if (press) begin
                        // Jump start: still kill the lights, report immediately.
                        bus.fsm_en        <= 1'b1;
                        bus.result_valid  <= 1'b1;
                        bus.reaction_time <= '0;
                        bus.jump_start    <= 1'b1;
                        bus.timeout       <= 1'b0;
                        state             <= IDLE;
                    end else if (bus.tick) begin
                        hold_cnt <= hold_cnt - 9'd1;
                        if (hold_cnt == 9'd1) begin
                            bus.fsm_en <= 1'b1;
                            rcnt       <= '0;
                            state      <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    // Press takes priority over a coincident tick.
                    if (press) begin
                        bus.result_valid  <= 1'b1;
                        bus.reaction_time <= rcnt;
                        bus.jump_start    <= 1'b0;
                        bus.timeout       <= 1'b0;
                        state             <= IDLE;
                    end else if (bus.tick) begin
                        rcnt <= rcnt + CNT_ONE;
                        if (rcnt == CNT_PRE) begin
                            bus.result_valid  <= 1'b1;
                            bus.reaction_time <= CNT_MAX;
                            bus.jump_start    <= 1'b0;
                            bus.timeout       <= 1'b1;
                            state             <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_f1_launch_ctrl.sv
// tb_f1_launch_ctrl: self-checking bench for f1_launch_ctrl (CNT_W=4).
// Contains a behavioural f1_fsm stand-in, a cycle reference model, a table
// of directed sequences and a randomized soak.
`timescale 1ns/1ps
module tb_f1_launch_ctrl;

    localparam int CNT_W     = 4;
    localparam int DELAY_MIN = 16;
    localparam int CMAX      = (1 << CNT_W) - 1;
`ifdef F1_BTN_SYNC_EN
    localparam int PLAT = 4;
`else
    localparam int PLAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       tick = 1'b0, start = 1'b0, btn = 1'b0;
    logic       ovr = 1'b0;
    logic [7:0] ovr_val = 8'h00;
    logic [7:0] env_lights;

    f1_launch_ctrl_if #(.CNT_W(CNT_W)) bus ();

    assign bus.tick      = tick;
    assign bus.start     = start;
    assign bus.btn       = btn;
    assign bus.lights_in = ovr ? ovr_val : env_lights;

    f1_launch_ctrl #(.CNT_W(CNT_W), .DELAY_MIN(DELAY_MIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // f1_fsm stand-in: each en shifts in one more lit lamp; en when all lit clears them.
    always @(posedge clk or negedge rst) begin
        if (!rst)            env_lights <= 8'h00;
        else if (bus.fsm_en) env_lights <= (env_lights == 8'hFF) ? 8'h00 : {env_lights[6:0], 1'b1};
    end

    // ---------------- reference model ----------------
    typedef enum int {P_IDLE, P_LIGHTS, P_HOLD, P_ARMED} phase_t;
    phase_t m_phase = P_IDLE;
    int     m_lfsr = 1, m_held = 0, m_count = 0;
    bit [7:0] m_bh = '0;
    bit     e_en = 0, e_rv = 0, e_js = 0, e_to = 0;
    int     e_rt = 0, e_dv = 0;

    initial forever begin
        bit pr;
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_phase = P_IDLE; m_lfsr = 1; m_held = 0; m_count = 0; m_bh = '0;
            e_en = 0; e_rv = 0; e_js = 0; e_to = 0; e_rt = 0; e_dv = 0;
        end else begin
`ifdef F1_BTN_SYNC_EN
            pr = m_bh[2] && !m_bh[3];
`else
            pr = m_bh[0] && !m_bh[1];
`endif
            e_en = 0; e_rv = 0;
            case (m_phase)
                P_IDLE:   if (start && bus.lights_in == 8'h00) m_phase = P_LIGHTS;
                P_LIGHTS: begin
                    if (bus.lights_in == 8'hFF) begin
                        e_dv = DELAY_MIN + m_lfsr; m_held = 0; m_phase = P_HOLD;
                    end else if (tick) e_en = 1;
                end
                P_HOLD: begin
                    if (pr) begin
                        e_en = 1; e_rv = 1; e_js = 1; e_to = 0; e_rt = 0; m_phase = P_IDLE;
                    end else if (tick) begin
                        m_held++;
                        if (m_held == e_dv) begin e_en = 1; m_count = 0; m_phase = P_ARMED; end
                    end
                end
                P_ARMED: begin
                    if (pr) begin
                        e_rv = 1; e_js = 0; e_to = 0; e_rt = m_count; m_phase = P_IDLE;
                    end else if (tick) begin
                        m_count++;
                        if (m_count == CMAX) begin
                            e_rv = 1; e_js = 0; e_to = 1; e_rt = CMAX; m_phase = P_IDLE;
                        end
                    end
                end
                default: m_phase = P_IDLE;
            endcase
            m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1)) & 127;
            m_bh   = {m_bh[6:0], btn};
        end
    end

    int n_cmp = 0, n_bad = 0;

    always @(negedge clk) begin
        if (rst) begin
            n_cmp++;
            if (bus.fsm_en !== e_en || bus.busy !== (m_phase != P_IDLE) ||
                bus.result_valid !== e_rv || int'(bus.reaction_time) != e_rt ||
                bus.jump_start !== e_js || bus.timeout !== e_to || int'(bus.delay_val) != e_dv) begin
                n_bad++;
                if (n_bad < 30)
                    $display("FAIL model_cycle t=%0t: got en=%b busy=%b rv=%b rt=%0d js=%b to=%b dv=%0d, required en=%b busy=%b rv=%b rt=%0d js=%b to=%b dv=%0d",
                             $time, bus.fsm_en, bus.busy, bus.result_valid, bus.reaction_time,
                             bus.jump_start, bus.timeout, bus.delay_val,
                             e_en, m_phase != P_IDLE, e_rv, e_rt, e_js, e_to, e_dv);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic cyc(input bit t);
        tick = t;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; tick = 1'b0; start = 1'b0; btn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic to_hold(input string nm, output int dv);
        int pulses, guard;
        chk({nm, "_idle_busy"}, int'(bus.busy), 0);
        start = 1'b1; cyc(0); start = 1'b0;
        chk({nm, "_busy_after_start"}, int'(bus.busy), 1);
        cyc(0); cyc(0);
        pulses = 0; guard = 0;
        while (bus.lights_in != 8'hFF && guard < 12) begin
            cyc(1);
            if (bus.fsm_en) pulses++;
            cyc(0); cyc(0); cyc(0);
            guard++;
        end
        chk({nm, "_seq_pulses"}, pulses, 8);
        chk({nm, "_busy_hold"}, int'(bus.busy), 1);
        dv = int'(bus.delay_val);
        chk({nm, "_dv_range"}, int'(dv >= 17 && dv <= 143), 1);
        chk({nm, "_dv_model"}, dv, e_dv);
    endtask

    typedef struct {
        string name;
        int    mode;   // 0: no press, 1: press n ticks after lights-out, 2: press at HOLD tick n
        int    n;
        int    exp_js;
        int    exp_to;
        int    exp_rt;
    } vec_t;

    task automatic run_vec(input vec_t v, output int dv);
        int held, ticks;
        bit lo, seen;
        to_hold(v.name, dv);
        if (v.mode == 2) begin
            repeat (v.n) begin cyc(1); cyc(0); cyc(0); cyc(0); end
            btn = 1'b1;
            repeat (PLAT) cyc(0);
            chk({v.name, "_lights_out_en"}, int'(bus.fsm_en), 1);
        end else begin
            held = 0; lo = 0;
            while (!lo && held < 300) begin
                cyc(1); held++;
                lo = bus.fsm_en;
                cyc(0); cyc(0); cyc(0);
            end
            chk({v.name, "_lights_out_tick"}, held, dv);
            if (v.mode == 1) begin
                repeat (v.n) begin cyc(1); cyc(0); cyc(0); cyc(0); end
                btn = 1'b1;
                repeat (PLAT) cyc(0);
            end else begin
                ticks = 0; seen = 0;
                while (!seen && ticks < 40) begin
                    cyc(1); ticks++;
                    seen = bus.result_valid;
                    if (!seen) begin cyc(0); cyc(0); cyc(0); end
                end
                chk({v.name, "_timeout_ticks"}, ticks, CMAX);
            end
        end
        chk({v.name, "_rv"},  int'(bus.result_valid),  1);
        chk({v.name, "_js"},  int'(bus.jump_start),    v.exp_js);
        chk({v.name, "_to"},  int'(bus.timeout),       v.exp_to);
        chk({v.name, "_rt"},  int'(bus.reaction_time), v.exp_rt);
        cyc(0);
        chk({v.name, "_rv_one_cycle"}, int'(bus.result_valid), 0);
        chk({v.name, "_idle"}, int'(bus.busy), 0);
        chk({v.name, "_rt_held"}, int'(bus.reaction_time), v.exp_rt);
        btn = 1'b0;
        repeat (4) cyc(0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got no finish by 3ms, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        vec_t vt[6];
        int dv, dv1, dv2, gap, gap_need;
        bit t;

        vt[0] = '{"react10", 1, 10, 0, 0, 10};
        vt[1] = '{"react0",  1, 0,  0, 0, 0};
        vt[2] = '{"react14", 1, 14, 0, 0, 14};
        vt[3] = '{"jump3",   2, 3,  1, 0, 0};
        vt[4] = '{"timeout", 0, 0,  0, 1, CMAX};
        vt[5] = '{"jump1",   2, 1,  1, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   int'(bus.busy), 0);
        chk("rst_fsm_en", int'(bus.fsm_en), 0);
        chk("rst_rv",     int'(bus.result_valid), 0);
        chk("rst_dv",     int'(bus.delay_val), 0);
        chk("rst_rt",     int'(bus.reaction_time), 0);
        chk("rst_js",     int'(bus.jump_start), 0);
        chk("rst_to",     int'(bus.timeout), 0);
        rst = 1'b1;
        repeat (3) cyc(0);

        for (int i = 0; i < 6; i++) run_vec(vt[i], dv);

        // Identical reset and stimulus must reproduce the same hold length.
        do_reset(); repeat (5) cyc(0);
        run_vec(vt[0], dv1);
        do_reset(); repeat (5) cyc(0);
        run_vec(vt[0], dv2);
        chk("repeat_dv", dv2, dv1);

        // Reset in HOLD, then a start with lamps showing is refused.
        do_reset(); repeat (3) cyc(0);
        to_hold("rsthold", dv);
        cyc(1); cyc(0);
        #2 rst = 1'b0;
        #1;
        chk("rsthold_busy",   int'(bus.busy), 0);
        chk("rsthold_fsm_en", int'(bus.fsm_en), 0);
        chk("rsthold_rv",     int'(bus.result_valid), 0);
        chk("rsthold_dv",     int'(bus.delay_val), 0);
        @(posedge clk); #1 rst = 1'b1;
        ovr = 1'b1; ovr_val = 8'h05;
        start = 1'b1; cyc(0); start = 1'b0;
        cyc(0); cyc(0);
        chk("lit_start_busy",   int'(bus.busy), 0);
        chk("lit_start_fsm_en", int'(bus.fsm_en), 0);
        ovr = 1'b0;

        // Randomized soak checked by the reference model every cycle.
        do_reset();
        gap = 0; gap_need = 4;
        for (int c = 0; c < 15000; c++) begin
            t = 1'b0;
            gap++;
            if (gap >= gap_need) begin
                t = 1'b1; gap = 0; gap_need = $urandom_range(3, 7);
            end
            start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 149) == 0) btn = ~btn;
            cyc(t);
        end
        start = 1'b0; btn = 1'b0;
        repeat (4) cyc(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/f1_launch_ctrl.md
Name: f1_launch_ctrl

Overview:
- Controls the F1 start-light sequence and measures the driver's reaction time.
- Sits directly around f1_fsm: drives its `en` input through `fsm_en` and consumes its 8-bit light pattern on `lights_in`.
- Steps the lights up on timebase ticks, holds all-lit for a pseudo-random delay, commands lights-out, then times the button press in ticks.

Parameters:
- CNT_W, 12: width of the reaction-time counter and of `reaction_time`.
- DELAY_MIN, 16: minimum all-lit hold in ticks (must be ≥1); hold = DELAY_MIN + L ticks, L = 7-bit LFSR snapshot (1..127).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle timebase pulse; consecutive pulses ≥3 clk apart.
- start  in  1  one-cycle request to begin a sequence.
- btn  in  1  driver button, level.
- lights_in  in  8  light pattern from f1_fsm.
- fsm_en  out  1  registered one-cycle advance pulse to f1_fsm `en`.
- busy  out  1  high in any state other than IDLE.
- delay_val  out  9  hold length in ticks latched on entry to HOLD (debug/verification).
- result_valid  out  1  one-cycle pulse when a result is available.
- reaction_time  out  CNT_W  ticks from lights-out to press; held until the next result.
- jump_start  out  1  result flag: press occurred before lights-out; held with the result.
- timeout  out  1  result flag: counter saturated without a press; held with the result.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; LFSR = 7'h01; internal counters 0; button edge register 0.
- LFSR:
  - 7-bit, x^7+x^6+1, shifts every clk regardless of state.
  - Never all-zero.
  - Sequence after reset is deterministic.
- Button press event = rising edge of `btn` (btn=1 with previous sample 0). Detection adds one cycle of latency.
- `fsm_en` is asserted exactly one cycle after the qualifying condition, high for exactly one cycle.
- States and transitions:
  - IDLE:
    - start=1 and lights_in==8'h00 → SEQ.
    - start with any other lights_in is ignored.
  - SEQ:
    - Each tick with lights_in != 8'hFF → fsm_en pulse.
    - When lights_in==8'hFF → HOLD; in that cycle latch delay_val = DELAY_MIN + LFSR and load the hold counter.
  - HOLD:
    - Count ticks.
    - On the delay_val-th tick → fsm_en pulse (f1_fsm S8→S0, lights out); clear the reaction counter; → ARMED.
    - Press in HOLD → fsm_en pulse (lights out), jump_start=1, timeout=0, reaction_time=0, result_valid pulse; → IDLE.
  - ARMED:
    - Reaction counter increments on each tick.
    - Press → reaction_time = counter, jump_start=0, timeout=0, result_valid pulse; → IDLE.
    - If press and tick occur in the same cycle, the press wins and that tick is not counted.
    - Counter reaching all-ones → timeout=1, reaction_time = all-ones, result_valid pulse; → IDLE.
- `result_valid` pulses exactly once per completed sequence.
- `reaction_time`, `jump_start` and `timeout` change only in the result_valid cycle.
- `start` outside IDLE is ignored.
- `btn` outside HOLD/ARMED is ignored.
- Reset mid-sequence returns to IDLE immediately. No result is issued. f1_fsm is reset by its own reset.

Optional Feature:
- Macro F1_BTN_SYNC_EN.
- Defined: `btn` passes through a 2-flop synchronizer (reset to 0) before edge detection. Press latency grows by 2 cycles. Counting rules are otherwise unchanged.
- Undefined: `btn` is sampled directly by the edge register.

Test Plan:
- Reset, then start with lights_in=0 and tick every 4 clk → 8 fsm_en pulses, each one clk after its tick; HOLD entered when lights_in=8'hFF; busy=1 throughout.
- Full run, press btn 10 ticks after lights-out → result_valid pulse, reaction_time=10, jump_start=0, timeout=0; state IDLE.
- Press btn at tick 3 of HOLD → fsm_en pulse, result_valid with jump_start=1, reaction_time=0.
- CNT_W=4, no press in ARMED → after 15 ticks result_valid with timeout=1, reaction_time=4'hF.
- Two runs after identical reset and stimulus → identical delay_val in both runs; value in 17..143; lights-out fsm_en on exactly the delay_val-th tick of HOLD.
- Assert rst=0 during HOLD → busy=0, fsm_en=0 and result_valid=0 immediately; start with lights_in=8'h05 then ignored (busy stays 0).
